// File: rtl/sprite_motion_ctrl.sv
// ---------------------------------------------------------------------------
// sprite_motion_ctrl
// Moves a 64x64 sprite across an 800x480 visible area once per frame and
// reflects it off the edges. Runs entirely in the pixel clock domain.
//
// Optional feature macro: SPRITE_GRAVITY_EN
//   defined   : vy gains +1 (saturating at +MAX_SPEED) at every step before
//               the Y add, so a floor bounce produces a ballistic arc.
//   undefined : vy only changes sign on a Y bounce.
//
// Ports:
//   i_clk_pix   pixel clock (only clock)
//   i_reset     asynchronous active-high reset
//   i_frame_int frame marker; only its rising edge starts a step
//   i_pause     when 1, frame edges in IDLE are discarded
//   i_load      one-cycle strobe to load i_load_vx / i_load_vy (clamped)
//   o_offset_x  registered signed sprite X
//   o_offset_y  registered signed sprite Y
//   o_hit_x     one-cycle pulse in COMMIT when X bounced
//   o_hit_y     one-cycle pulse in COMMIT when Y bounced
//   o_busy      high in STEP_X, STEP_Y and COMMIT
//   o_overrun   sticky: a frame edge arrived while busy
// ---------------------------------------------------------------------------
module sprite_motion_ctrl #(
  parameter int SCREEN_W  = 800,
  parameter int SCREEN_H  = 480,
  parameter int SPRITE_W  = 64,
  parameter int SPRITE_H  = 64,
  parameter int X0        = 100,
  parameter int Y0        = 50,
  parameter int DEF_VX    = 2,
  parameter int DEF_VY    = 1,
  parameter int MAX_SPEED = 7
) (
  input  logic               i_clk_pix,
  input  logic               i_reset,
  input  logic               i_frame_int,
  input  logic               i_pause,
  input  logic               i_load,
  input  logic signed [3:0]  i_load_vx,
  input  logic signed [3:0]  i_load_vy,
  output logic signed [15:0] o_offset_x,
  output logic signed [15:0] o_offset_y,
  output logic               o_hit_x,
  output logic               o_hit_y,
  output logic               o_busy,
  output logic               o_overrun
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STEP_X = 2'd1,
    STEP_Y = 2'd2,
    COMMIT = 2'd3
  } state_t;

  localparam logic signed [16:0] LP_XMAX  = 17'(SCREEN_W - SPRITE_W);
  localparam logic signed [16:0] LP_YMAX  = 17'(SCREEN_H - SPRITE_H);
  localparam logic signed [4:0]  LP_MAX5  = 5'(MAX_SPEED);
  localparam logic signed [4:0]  LP_NMAX5 = -5'(MAX_SPEED);

  // Clamp a loaded velocity into [-MAX_SPEED, +MAX_SPEED].
  function automatic logic signed [3:0] clamp_vel(input logic signed [3:0] v);
    logic signed [4:0] v5;
    v5 = 5'(v);
    if (v5 > LP_MAX5) begin
      clamp_vel = 4'(LP_MAX5);
    end else if (v5 < LP_NMAX5) begin
      clamp_vel = 4'(LP_NMAX5);
    end else begin
      clamp_vel = v;
    end
  endfunction

  // One axis step with mirror reflection; result is {hit, new_position}.
  // The sum is 17 bits so a negative overshoot is never lost to wrap.
  function automatic logic [16:0] reflect(input logic signed [15:0] pos,
                                          input logic signed [3:0]  vel,
                                          input logic signed [16:0] lim);
    logic signed [16:0] n;
    n = 17'(pos) + 17'(vel);
    if (n < 17'sd0) begin
      reflect = {1'b1, 16'(-n)};
    end else if (n > lim) begin
      reflect = {1'b1, 16'((lim <<< 1) - n)};
    end else begin
      reflect = {1'b0, 16'(n)};
    end
  endfunction

  state_t             r_state;
  state_t             w_state_n;
  logic               r_frame_d;
  logic signed [15:0] r_px;
  logic signed [15:0] r_py;
  logic signed [15:0] r_nx;
  logic signed [15:0] r_ny;
  logic signed [3:0]  r_vx;
  logic signed [3:0]  r_vy;
  logic               r_hx;
  logic               r_hit_x;
  logic               r_hit_y;
  logic               r_busy;
  logic               r_overrun;
  logic               r_pend_v;
  logic signed [3:0]  r_pend_vx;
  logic signed [3:0]  r_pend_vy;

  logic               w_edge;
  logic signed [3:0]  w_vy_eff;
  logic [16:0]        w_ref_x;
  logic [16:0]        w_ref_y;

  assign w_edge = i_frame_int & ~r_frame_d;

`ifdef SPRITE_GRAVITY_EN
  localparam logic signed [3:0] LP_MAX4 = 4'(MAX_SPEED);
  assign w_vy_eff = (r_vy >= LP_MAX4) ? r_vy : r_vy + 4'sd1;
`else
  assign w_vy_eff = r_vy;
`endif

  assign w_ref_x = reflect(r_px, r_vx, LP_XMAX);
  assign w_ref_y = reflect(r_py, w_vy_eff, LP_YMAX);

  // State register.
  always_ff @(posedge i_clk_pix or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      IDLE: begin
        if (w_edge && !i_pause) begin
          w_state_n = STEP_X;
        end else begin
          w_state_n = IDLE;
        end
      end
      STEP_X:  w_state_n = STEP_Y;
      STEP_Y:  w_state_n = COMMIT;
      COMMIT:  w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
  end

  // Datapath: velocity, staged positions, pending load, flags.
  always_ff @(posedge i_clk_pix or posedge i_reset) begin
    if (i_reset) begin
      r_frame_d <= 1'b0;
      r_px      <= 16'(X0);
      r_py      <= 16'(Y0);
      r_nx      <= 16'(X0);
      r_ny      <= 16'(Y0);
      r_vx      <= 4'(DEF_VX);
      r_vy      <= 4'(DEF_VY);
      r_hx      <= 1'b0;
      r_hit_x   <= 1'b0;
      r_hit_y   <= 1'b0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
      r_pend_v  <= 1'b0;
      r_pend_vx <= 4'sd0;
      r_pend_vy <= 4'sd0;
    end else begin
      r_frame_d <= i_frame_int;
      r_busy    <= (w_state_n != IDLE);
      r_hit_x   <= 1'b0;
      r_hit_y   <= 1'b0;
      if (w_edge && (r_state != IDLE)) begin
        r_overrun <= 1'b1;
      end
      // Loads during a step are parked so the step in flight is untouched.
      if (i_load && (r_state != IDLE)) begin
        r_pend_v  <= 1'b1;
        r_pend_vx <= clamp_vel(i_load_vx);
        r_pend_vy <= clamp_vel(i_load_vy);
      end
      case (r_state)
        IDLE: begin
          // A fresh load is newer than anything pending, so it wins.
          if (i_load) begin
            r_vx     <= clamp_vel(i_load_vx);
            r_vy     <= clamp_vel(i_load_vy);
            r_pend_v <= 1'b0;
          end else if (r_pend_v) begin
            r_vx     <= r_pend_vx;
            r_vy     <= r_pend_vy;
            r_pend_v <= 1'b0;
          end
        end
        STEP_X: begin
          r_nx <= w_ref_x[15:0];
          r_hx <= w_ref_x[16];
          if (w_ref_x[16]) begin
            r_vx <= -r_vx;
          end
        end
        STEP_Y: begin
          r_ny    <= w_ref_y[15:0];
          r_vy    <= w_ref_y[16] ? -w_vy_eff : w_vy_eff;
          // Registered here so the pulses are high during the COMMIT cycle.
          r_hit_x <= r_hx;
          r_hit_y <= w_ref_y[16];
        end
        COMMIT: begin
          r_px <= r_nx;
          r_py <= r_ny;
        end
        default: begin
          r_px <= r_px;
        end
      endcase
    end
  end

  assign o_offset_x = r_px;
  assign o_offset_y = r_py;
  assign o_hit_x    = r_hit_x;
  assign o_hit_y    = r_hit_y;
  assign o_busy     = r_busy;
  assign o_overrun  = r_overrun;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
module tb_sprite_motion_ctrl;

  logic               clk = 1'b0;
  logic               rst;
  logic               frame_int;
  logic               pause;
  logic               load;
  logic signed [3:0]  load_vx;
  logic signed [3:0]  load_vy;
  logic signed [15:0] offset_x;
  logic signed [15:0] offset_y;
  logic               hit_x;
  logic               hit_y;
  logic               busy;
  logic               overrun;

  sprite_motion_ctrl dut (
    .i_clk_pix  (clk),
    .i_reset    (rst),
    .i_frame_int(frame_int),
    .i_pause    (pause),
    .i_load     (load),
    .i_load_vx  (load_vx),
    .i_load_vy  (load_vy),
    .o_offset_x (offset_x),
    .o_offset_y (offset_y),
    .o_hit_x    (hit_x),
    .o_hit_y    (hit_y),
    .o_busy     (busy),
    .o_overrun  (overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic        hx;
    logic        hy;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input int act, input int expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: a step output is the busy window; compare when busy drops.
  bit   in_step = 1'b0;
  int   bcnt, hxc, hyc;
  exp_t e;
  always @(negedge clk) begin
    if (rst) begin
      in_step = 1'b0;
    end else if (busy) begin
      if (!in_step) begin
        in_step = 1'b1;
        bcnt = 0; hxc = 0; hyc = 0;
      end
      bcnt++;
      if (hit_x) hxc++;
      if (hit_y) hyc++;
    end else begin
      if (hit_x || hit_y) check("hit_outside_busy", 1, 0);
      if (in_step) begin
        in_step = 1'b0;
        if (exp_q.size() == 0) begin
          check("unexpected_step", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("offset_x", int'(offset_x), int'(e.x));
          check("offset_y", int'(offset_y), int'(e.y));
          check("hit_x_cycles", hxc, int'(e.hx));
          check("hit_y_cycles", hyc, int'(e.hy));
          check("busy_cycles", bcnt, 3);
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) check("busy_timeout", 1, 0);
  endtask

  // Edge (optionally with simultaneous load) and queue the expected result.
  task automatic do_step(input bit ld, input logic [3:0] vx, input logic [3:0] vy,
                         input int ex, input int ey, input bit hx, input bit hy);
    exp_q.push_back({16'(ex), 16'(ey), hx, hy});
    @(posedge clk); #1;
    frame_int = 1'b1; load = ld; load_vx = vx; load_vy = vy;
    @(posedge clk); #1;
    frame_int = 1'b0; load = 1'b0;
    wait_idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; frame_int = 1'b0; pause = 1'b0; load = 1'b0;
    load_vx = 4'h0; load_vy = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_x", int'(offset_x), 100);
    check("reset_y", int'(offset_y), 50);
    check("reset_busy", int'(busy), 0);
    check("reset_overrun", int'(overrun), 0);
    check("reset_hits", int'({hit_x, hit_y}), 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Default velocity (2,1).
    do_step(1'b0, 4'h0, 4'h0, 102, 51, 1'b0, 1'b0);
    // Travel right at 7 to x=732 with vy=0.
    do_step(1'b1, 4'h7, 4'h0, 109, 51, 1'b0, 1'b0);
    for (int k = 2; k <= 90; k++) do_step(1'b0, 4'h0, 4'h0, 102 + 7 * k, 51, 1'b0, 1'b0);
    do_step(1'b1, 4'h1, 4'h0, 733, 51, 1'b0, 1'b0);
    // Right wall: 733+5=738 > 736 -> 734, vx becomes -5.
    do_step(1'b1, 4'h5, 4'h1, 734, 52, 1'b1, 1'b0);
    // Travel left at -7 to x=6.
    do_step(1'b1, 4'h9, 4'h0, 727, 52, 1'b0, 1'b0);
    for (int k = 2; k <= 104; k++) do_step(1'b0, 4'h0, 4'h0, 734 - 7 * k, 52, 1'b0, 1'b0);
    // Landing exactly on 1, then move up to y=2 with vx=0 (zero velocity, no hit).
    do_step(1'b1, 4'hB, 4'h9, 1, 45, 1'b0, 1'b0);
    do_step(1'b1, 4'h0, 4'h9, 1, 38, 1'b0, 1'b0);
    for (int k = 2; k <= 6; k++) do_step(1'b0, 4'h0, 4'h0, 1, 45 - 7 * k, 1'b0, 1'b0);
    do_step(1'b1, 4'h0, 4'hF, 1, 2, 1'b0, 1'b0);
    // Corner: vx=-3, vy=-4 from (1,2) -> (2,2) with both hits.
    do_step(1'b1, 4'hD, 4'hC, 2, 2, 1'b1, 1'b1);

    // frame_int held high 10 cycles -> single step with v=(3,4).
    exp_q.push_back({16'd5, 16'd6, 1'b0, 1'b0});
    @(posedge clk); #1; frame_int = 1'b1;
    repeat (10) @(posedge clk);
    #1; frame_int = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("hold_no_overrun", int'(overrun), 0);

    // Second edge two cycles after the first -> overrun, one step only.
    exp_q.push_back({16'd8, 16'd10, 1'b0, 1'b0});
    @(posedge clk); #1; frame_int = 1'b1;
    @(posedge clk); #1; frame_int = 1'b0;
    @(posedge clk); #1; frame_int = 1'b1;
    @(posedge clk); #1; frame_int = 1'b0;
    wait_idle();
    repeat (4) @(posedge clk);
    #1;
    check("overrun_set", int'(overrun), 1);
    check("overrun_pos_x", int'(offset_x), 8);

    // Paused edges do nothing.
    pause = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1; frame_int = 1'b1;
      @(posedge clk); #1; frame_int = 1'b0;
      repeat (4) @(posedge clk);
    end
    #1;
    check("pause_x", int'(offset_x), 8);
    check("pause_y", int'(offset_y), 10);
    check("pause_busy", int'(busy), 0);
    pause = 1'b0;

    // -8 clamps to -7: 8-7 = 1.
    do_step(1'b1, 4'h8, 4'h0, 1, 10, 1'b0, 1'b0);

    // Load during STEP_X is deferred: this step uses -7 (bounce to 6), next uses +1.
    exp_q.push_back({16'd6, 16'd10, 1'b1, 1'b0});
    @(posedge clk); #1; frame_int = 1'b1;
    @(posedge clk); #1; frame_int = 1'b0; load = 1'b1; load_vx = 4'h1; load_vy = 4'h0;
    @(posedge clk); #1; load = 1'b0;
    wait_idle();
    do_step(1'b0, 4'h0, 4'h0, 7, 10, 1'b0, 1'b0);

    // Reset during STEP_Y: immediate return to reset values.
    @(posedge clk); #1; frame_int = 1'b1;
    @(posedge clk); #1; frame_int = 1'b0;
    @(posedge clk); #1;
    check("midstep_busy_before", int'(busy), 1);
    rst = 1'b1;
    #1;
    check("midstep_rst_x", int'(offset_x), 100);
    check("midstep_rst_y", int'(offset_y), 50);
    check("midstep_rst_busy", int'(busy), 0);
    check("midstep_rst_overrun", int'(overrun), 0);
    @(posedge clk); #1; rst = 1'b0;
    repeat (2) @(posedge clk);
    do_step(1'b0, 4'h0, 4'h0, 102, 51, 1'b0, 1'b0);

    repeat (5) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_motion_ctrl.md
Name: sprite_motion_ctrl

Overview:
- Produces the per-frame sprite offsets (offset_x_in / offset_y_in) consumed by the LCD VGA timing/pixel stage.
- Advances a 64x64 sprite by a signed velocity once per frame, triggered by that stage's frame_int.
- Reflects the sprite off the visible 800x480 area edges.
- Runs in the pixel clock domain, so frame_int and the offsets need no CDC.

Parameters:
- SCREEN_W, 800, visible width in pixels
- SCREEN_H, 480, visible height in pixels
- SPRITE_W, 64, sprite width
- SPRITE_H, 64, sprite height
- X0, 100, reset X position
- Y0, 50, reset Y position
- DEF_VX, 2, reset X velocity (signed)
- DEF_VY, 1, reset Y velocity (signed)
- MAX_SPEED, 7, velocity magnitude clamp

Ports:
- clk_pix  in  1  pixel clock; the only clock
- reset  in  1  asynchronous, active-high reset
- frame_int  in  1  frame marker from the LCD stage; high one or more cycles per frame
- pause  in  1  when 1, frame steps are skipped
- load  in  1  one-cycle strobe: load new velocity
- load_vx  in  4  signed X velocity for load
- load_vy  in  4  signed Y velocity for load
- offset_x  out  16  signed sprite X, registered
- offset_y  out  16  signed sprite Y, registered
- hit_x  out  1  one-cycle pulse: X wall bounce this step
- hit_y  out  1  one-cycle pulse: Y wall bounce this step
- busy  out  1  step in progress
- overrun  out  1  sticky: frame edge arrived while busy

Behaviour:
- Reset (async, reset=1) values:
  - offset_x=X0, offset_y=Y0.
  - vx=DEF_VX, vy=DEF_VY.
  - hit_x=hit_y=busy=overrun=0.
  - State=IDLE; pending-load register cleared; frame_int edge history=0.
- Edge detect: rising edge = frame_int & ~frame_int_d. Only the edge counts; level duration is irrelevant.
- States: IDLE -> STEP_X -> STEP_Y -> COMMIT -> IDLE.
  - busy=1 in STEP_X, STEP_Y and COMMIT.
- IDLE:
  - Apply any pending load first.
  - Then, on an edge with pause=0, go to STEP_X.
  - An edge with pause=1 is discarded and the state stays IDLE.
- STEP_X: nx = px + vx (17-bit signed).
  - If nx < 0: px_n = -nx, vx = -vx, flag hit_x.
  - Else if nx > SCREEN_W-SPRITE_W: px_n = 2*(SCREEN_W-SPRITE_W) - nx, vx = -vx, flag hit_x.
  - Else px_n = nx.
  - Landing exactly on 0 or on SCREEN_W-SPRITE_W is not a hit.
- STEP_Y: same rule using vy, SCREEN_H-SPRITE_H and hit_y.
- COMMIT:
  - offset_x and offset_y update together in this cycle. They never reflect a half-step.
  - hit_x/hit_y assert for exactly this one cycle.
- Latency: edge detected in cycle N -> offsets updated at the end of cycle N+3. Outputs hold between steps.
- Velocity values:
  - Stored as 4-bit signed.
  - Loads are clamped to [-MAX_SPEED, +MAX_SPEED]; -8 becomes -7.
  - Velocity 0 is legal: no motion, no hit.
- load while IDLE: applied in the same cycle. The new velocity is used by a step started by a simultaneous edge.
- load while busy: captured into the pending register (latest wins) and applied on return to IDLE. It never alters a step in flight.
- Edge while busy: ignored and overrun set to 1. overrun is cleared only by reset.
- Reset mid-step: the step is abandoned and all state returns to reset values immediately.

Optional Feature:
- Macro: SPRITE_GRAVITY_EN.
- Defined:
  - In STEP_Y, vy is incremented by 1 before the add, saturating at +MAX_SPEED.
  - A floor bounce then negates it, giving a ballistic arc.
  - pause also freezes gravity.
- Undefined: vy is constant except for sign flips on bounce.

Test Plan:
- Reset release, one frame_int pulse -> 3 cycles after the edge: offset_x=102, offset_y=51; hit_x=hit_y=0; busy high for exactly 3 cycles.
- load vx=+5 at px=733, then edge -> nx=738 > 736: offset_x=734, vx=-5, hit_x pulse of 1 cycle; offset_y advances normally.
- load vx=-3,vy=-4 with px=1, py=2, then edge -> offset_x=2, offset_y=2; hit_x and hit_y pulse in the same cycle.
- frame_int held high 10 cycles -> exactly one step. Second edge 2 cycles after the first -> ignored, overrun=1, position advanced once.
- pause=1 across 3 frame edges -> offsets unchanged, no hits. load_vx=-8 -> stored as -7.
- With SPRITE_GRAVITY_EN: vy=0, py=50, 3 edges -> offset_y=51, 53, 56. Assert reset mid-STEP_Y -> offsets 100/50, busy=0 immediately.
